// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port between NUM_REQ valid/ready producers.
// Grants are registered one-hot and bounded to MAX_BURST transfers per owner.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_we,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          busy
);
    localparam int         PW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t               state, state_n;
    logic [PW-1:0]        owner, owner_n;
    logic [PW-1:0]        rr_ptr, rr_ptr_n;
    logic [3:0]           burst_cnt, burst_cnt_n;
    logic [NUM_REQ-1:0]   gnt_n;
    logic [NUM_REQ-1:0]   winner_onehot;
    logic [PW-1:0]        search_ptr;
    logic [PW-1:0]        scan_idx;
    logic [PW-1:0]        winner;
    logic                 found;
    logic                 transfer;
    logic                 release_own;

    // Explicit wrap so non-power-of-2 NUM_REQ never reaches an unused index.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        if (int'(p) == NUM_REQ - 1)
            return '0;
        else
            return p + PW'(1);
    endfunction

    assign busy        = (state == GRANT);
    assign req_ready   = (busy && !fifo_full) ? gnt : '0;
    assign transfer    = req_valid[owner] & req_ready[owner];
    assign fifo_we     = transfer;
    assign fifo_data   = busy ? req_data[owner*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign release_own = !req_valid[owner] || (transfer && burst_cnt == BURST_LAST);

    // On release the scan starts just past the owner, so a still-valid owner is seen last.
    assign search_ptr    = busy ? wrap_inc(owner) : rr_ptr;
    assign winner_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;

    always_comb begin
        found    = 1'b0;
        winner   = search_ptr;
        scan_idx = search_ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
            scan_idx = wrap_inc(scan_idx);
        end
    end

    // NOTE: every next-state signal gets a default first, so no path can infer a latch.
    always_comb begin
        state_n     = state;
        owner_n     = owner;
        rr_ptr_n    = rr_ptr;
        burst_cnt_n = burst_cnt;
        gnt_n       = gnt;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n     = GRANT;
                    owner_n     = winner;
                    gnt_n       = winner_onehot;
                    burst_cnt_n = '0;
                end
            end
            GRANT: begin
                if (release_own) begin
                    rr_ptr_n = search_ptr;
                    if (found) begin
                        owner_n     = winner;
                        gnt_n       = winner_onehot;
                        burst_cnt_n = '0;
                    end else begin
                        state_n = IDLE;
                        gnt_n   = '0;
                    end
                end else if (transfer) begin
                    burst_cnt_n = burst_cnt + 4'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            gnt       <= '0;
        end else begin
            state     <= state_n;
            owner     <= owner_n;
            rr_ptr    <= rr_ptr_n;
            burst_cnt <= burst_cnt_n;
            gnt       <= gnt_n;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a 4-producer instance and a 3-producer instance.
module tb_fifo_wr_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [3:0]  v4 = '0;
    logic [31:0] d4 = '0;
    logic [3:0]  rdy4;
    logic        full4 = 1'b0;
    logic        we4;
    logic [7:0]  fd4;
    logic [3:0]  gnt4;
    logic        busy4;

    logic [2:0]  v3 = '0;
    logic [23:0] d3 = '0;
    logic [2:0]  rdy3;
    logic        full3 = 1'b0;
    logic        we3;
    logic [7:0]  fd3;
    logic [2:0]  gnt3;
    logic        busy3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .MAX_BURST(4)) dut4 (
        .clk(clk), .rst(rst), .req_valid(v4), .req_data(d4), .req_ready(rdy4),
        .fifo_full(full4), .fifo_we(we4), .fifo_data(fd4), .gnt(gnt4), .busy(busy4)
    );

    fifo_wr_arbiter #(.DATA_WIDTH(8), .NUM_REQ(3), .MAX_BURST(4)) dut3 (
        .clk(clk), .rst(rst), .req_valid(v3), .req_data(d3), .req_ready(rdy3),
        .fifo_full(full3), .fifo_we(we3), .fifo_data(fd3), .gnt(gnt3), .busy(busy3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        v4 = '0; v3 = '0; full4 = 1'b0; full3 = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state, with requests present so outputs must be forced low by reset.
        v4 = 4'b1111;
        #2;
        check("rst_gnt", 32'(gnt4), 32'h0);
        check("rst_ready", 32'(rdy4), 32'h0);
        check("rst_we", 32'(we4), 32'h0);
        check("rst_busy", 32'(busy4), 32'h0);
        do_reset();

        // Single producer 2: 4-word burst, zero-bubble re-grant, two more words.
        v4 = 4'b0100;
        d4 = '0;
        d4[23:16] = 8'h10;
        #1;
        check("t1_bubble_gnt", 32'(gnt4), 32'h0);
        check("t1_bubble_we", 32'(we4), 32'h0);
        tick();
        for (int w = 0; w < 6; w++) begin
            d4[23:16] = 8'(8'h10 + w);
            #1;
            check("t1_gnt", 32'(gnt4), 32'h4);
            check("t1_we", 32'(we4), 32'h1);
            check("t1_data", 32'(fd4), 32'(8'h10 + w));
            tick();
        end
        v4 = 4'b0000;
        #1;
        check("t1_drop_we", 32'(we4), 32'h0);
        tick();
        check("t1_idle_busy", 32'(busy4), 32'h0);
        check("t1_idle_gnt", 32'(gnt4), 32'h0);

        // All four valid: owners 0,1,2,3,0 with four writes each.
        do_reset();
        v4 = 4'b1111;
        d4 = 32'hA3A2A1A0;
        #1;
        check("t2_bubble_we", 32'(we4), 32'h0);
        tick();
        for (int n = 0; n < 20; n++) begin
            int own;
            own = (n / 4) % 4;
            check("t2_gnt", 32'(gnt4), 32'(1) << own);
            check("t2_ready", 32'(rdy4), 32'(1) << own);
            check("t2_we", 32'(we4), 32'h1);
            check("t2_data", 32'(fd4), 32'hA0 + 32'(own));
            tick();
        end

        // Producer 1 stalls on full after two writes, then finishes and rotates to 2.
        do_reset();
        v4 = 4'b0110;
        d4 = 32'h00_42_31_00;
        tick();
        for (int n = 0; n < 2; n++) begin
            check("t3_pre_gnt", 32'(gnt4), 32'h2);
            check("t3_pre_we", 32'(we4), 32'h1);
            tick();
        end
        full4 = 1'b1;
        for (int n = 0; n < 3; n++) begin
            #1;
            check("t3_full_we", 32'(we4), 32'h0);
            check("t3_full_ready", 32'(rdy4), 32'h0);
            check("t3_full_gnt", 32'(gnt4), 32'h2);
            check("t3_full_busy", 32'(busy4), 32'h1);
            tick();
        end
        full4 = 1'b0;
        for (int n = 0; n < 2; n++) begin
            #1;
            check("t3_post_gnt", 32'(gnt4), 32'h2);
            check("t3_post_we", 32'(we4), 32'h1);
            check("t3_post_data", 32'(fd4), 32'h31);
            tick();
        end
        check("t3_rot_gnt", 32'(gnt4), 32'h4);
        check("t3_rot_data", 32'(fd4), 32'h42);

        // Owner 3 drops after one write; grant wraps to producer 0.
        do_reset();
        v4 = 4'b1000;
        d4 = 32'h77_00_00_0C;
        tick();
        v4 = 4'b1001;
        #1;
        check("t4_own3_gnt", 32'(gnt4), 32'h8);
        check("t4_own3_we", 32'(we4), 32'h1);
        check("t4_own3_data", 32'(fd4), 32'h77);
        tick();
        v4 = 4'b0001;
        #1;
        check("t4_drop_we", 32'(we4), 32'h0);
        tick();
        check("t4_wrap_gnt", 32'(gnt4), 32'h1);
        check("t4_wrap_data", 32'(fd4), 32'h0C);
        check("t4_wrap_we", 32'(we4), 32'h1);

        // Async reset mid-burst (rr_ptr is 2 at that point), then restart from pointer 0.
        do_reset();
        v4 = 4'b0010;
        d4 = 32'h00_E2_55_E0;
        tick();
        repeat (5) tick();
        check("t5_pre_we", 32'(we4), 32'h1);
        check("t5_pre_gnt", 32'(gnt4), 32'h2);
        #2;
        rst = 1'b1;
        #1;
        check("t5_async_gnt", 32'(gnt4), 32'h0);
        check("t5_async_ready", 32'(rdy4), 32'h0);
        check("t5_async_we", 32'(we4), 32'h0);
        check("t5_async_busy", 32'(busy4), 32'h0);
        v4 = 4'b0101;
        tick();
        rst = 1'b0;
        #1;
        check("t5_rel_gnt", 32'(gnt4), 32'h0);
        tick();
        check("t5_restart_gnt", 32'(gnt4), 32'h1);
        check("t5_restart_data", 32'(fd4), 32'hE0);

        // Three-producer build: owners 0,1,2,0, never an index past 2.
        do_reset();
        v3 = 3'b111;
        d3 = 24'hC2C1C0;
        #1;
        check("t6_bubble_we", 32'(we3), 32'h0);
        tick();
        for (int n = 0; n < 16; n++) begin
            int own;
            own = (n / 4) % 3;
            check("t6_gnt", 32'(gnt3), 32'(1) << own);
            check("t6_ready", 32'(rdy3), 32'(1) << own);
            check("t6_we", 32'(we3), 32'h1);
            check("t6_data", 32'(fd3), 32'hC0 + 32'(own));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
